// File: rtl/regfile_write_ctrl_pkg.sv
// regfile_write_ctrl_pkg: shared widths, state encodings and clear length for the register-file write side
package regfile_write_ctrl_pkg;
  localparam int DEF_DW = 8;
  localparam int DEF_AW = 3;
  localparam int DEF_NREGS = 8;
  localparam int CLR_STEPS = 8;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DRAIN = 2'd1;
  localparam logic [1:0] CLEAR = 2'd2;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with flush; power-of-two DEPTH so pointers wrap naturally
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push && !flush) mem[wp] <= din;
endmodule

// File: rtl/regfile_write_ctrl.sv
// regfile_write_ctrl: queues row writes and issues them as a registered one-hot enable plus data,
// and sequences a row-by-row clear of the register file
module regfile_write_ctrl
  import regfile_write_ctrl_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW,
  parameter int NREGS = DEF_NREGS,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [AW-1:0]              wr_addr,
  input  logic [DW-1:0]              wr_data,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic [NREGS-1:0]           reg_en,
  output logic [DW-1:0]              reg_d,
  output logic [$clog2(DEPTH+1)-1:0] q_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(CLR_STEPS);
  logic [1:0] state;
  logic [IW-1:0] idx;
  logic full, empty, push, pop, clr_go, last;
  logic [AW+DW-1:0] head;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [NREGS-1:0] dec;
  assign {head_addr, head_data} = head;
  assign clr_busy = state == CLEAR;
  assign wr_ready = !full && !clr_busy;
  assign push = wr_valid && wr_ready;
  assign clr_go = clr_req && !clr_busy;
  assign pop = !empty && !clr_go;
  assign last = idx == IW'(CLR_STEPS - 1);
  // Out-of-range addresses still pop but decode to no row.
  assign dec = int'(head_addr) < NREGS ? NREGS'(1) << head_addr : '0;
  sync_fifo #(.DEPTH(DEPTH), .W(AW + DW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .flush(clr_go),
    .din({wr_addr, wr_data}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(q_count)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      reg_en <= '0;
      reg_d <= '0;
    end else if (clr_go) begin
      state <= CLEAR;
      idx <= '0;
      reg_en <= NREGS'(1);
      reg_d <= '0;
    end else if (clr_busy) begin
      state <= last ? IDLE : CLEAR;
      idx <= idx + 1'b1;
      reg_en <= last ? '0 : reg_en << 1;
    end else begin
      // A non-empty queue always pops here, so one entry left drains unless refilled.
      state <= (q_count > CW'(1) || push) ? DRAIN : IDLE;
      reg_en <= pop ? dec : '0;
      if (pop) reg_d <= head_data;
    end
endmodule

// File: tb/tb_regfile_write_ctrl.sv
// tb_regfile_write_ctrl: directed checks of the write front end with a behavioural model of the eight rows
module tb_regfile_write_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic wr_valid = 1'b0;
  logic wr_ready;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic clr_req = 1'b0;
  logic clr_busy;
  logic [7:0] reg_en;
  logic [7:0] reg_d;
  logic [2:0] q_count;
  logic [7:0] rows [8] = '{default: 8'h00};
  logic f_push = 1'b0, f_pop = 1'b0, f_flush = 1'b0;
  logic [7:0] f_din = '0, f_dout;
  logic f_full, f_empty;
  logic [2:0] f_count;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_write_ctrl dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .clr_req(clr_req), .clr_busy(clr_busy),
    .reg_en(reg_en), .reg_d(reg_d), .q_count(q_count)
  );

  sync_fifo #(.DEPTH(4), .W(8)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(f_push), .pop(f_pop), .flush(f_flush),
    .din(f_din), .dout(f_dout), .full(f_full), .empty(f_empty), .count(f_count)
  );

  // reg8 rows: capture reg_d on the edge where their enable is high
  always @(posedge clk)
    for (int r = 0; r < 8; r++)
      if (reg_en[r]) rows[r] <= reg_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset with a request held
    wr_valid = 1'b1;
    #23;
    chk("rst_en", reg_en, 0);
    chk("rst_d", reg_d, 0);
    chk("rst_busy", clr_busy, 0);
    chk("rst_qc", q_count, 0);
    @(negedge clk);
    wr_valid = 1'b0;
    rst_n = 1'b1;
    tick;
    chk("rel_ready", wr_ready, 1);
    chk("rel_qc", q_count, 0);
    chk("rel_en", reg_en, 0);

    // standalone FIFO: fill, overflow attempt, wrap, simultaneous push+pop
    f_push = 1'b1;
    for (int i = 0; i < 4; i++) begin
      f_din = 8'hA0 + 8'(i);
      tick;
    end
    chk("f_full", f_full, 1);
    chk("f_cnt4", f_count, 4);
    f_din = 8'hA4;
    tick;
    chk("f_ovf_cnt", f_count, 4);
    f_push = 1'b0;
    f_pop = 1'b1;
    chk("f_h0", f_dout, 8'hA0);
    tick;
    chk("f_h1", f_dout, 8'hA1);
    tick;
    chk("f_cnt2", f_count, 2);
    f_push = 1'b1;
    f_din = 8'hB0;
    chk("f_h2", f_dout, 8'hA2);
    tick;
    chk("f_pp_cnt", f_count, 2);
    f_pop = 1'b0;
    f_din = 8'hB1;
    tick;
    f_push = 1'b0;
    f_pop = 1'b1;
    chk("f_h3", f_dout, 8'hA3);
    tick;
    chk("f_wrap0", f_dout, 8'hB0);
    tick;
    chk("f_wrap1", f_dout, 8'hB1);
    tick;
    chk("f_empty", f_empty, 1);
    f_pop = 1'b0;

    // 2: single write
    wr_valid = 1'b1;
    wr_addr = 3'd3;
    wr_data = 8'hA5;
    tick;
    wr_valid = 1'b0;
    chk("s_qc", q_count, 1);
    chk("s_en0", reg_en, 0);
    tick;
    chk("s_en", reg_en, 8'h08);
    chk("s_d", reg_d, 8'hA5);
    chk("s_qc0", q_count, 0);
    tick;
    chk("s_en_off", reg_en, 0);
    chk("s_row3", rows[3], 8'hA5);
    chk("s_row2", rows[2], 8'h00);

    // 3: burst of six, drained at one per cycle
    wr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wr_addr = 3'(i);
      wr_data = 8'h10 + 8'(i);
      tick;
      chk("b_ready", wr_ready, 1);
      chk("b_qc", q_count, 1);
      if (i > 0) begin
        chk("b_en", reg_en, 32'(1) << (i - 1));
        chk("b_d", reg_d, 32'h10 + 32'(i - 1));
      end
    end
    wr_valid = 1'b0;
    tick;
    chk("b_en5", reg_en, 8'h20);
    chk("b_d5", reg_d, 8'h15);
    chk("b_qc0", q_count, 0);
    tick;
    chk("b_idle", reg_en, 0);
    chk("b_row0", rows[0], 8'h10);
    chk("b_row5", rows[5], 8'h15);

    // 4: queued writes then clear; the entry pushed at the clear edge is dropped
    wr_valid = 1'b1;
    wr_addr = 3'd6;
    wr_data = 8'h66;
    tick;
    wr_addr = 3'd7;
    wr_data = 8'h77;
    tick;
    chk("c_pre_en", reg_en, 8'h40);
    wr_addr = 3'd1;
    wr_data = 8'hEE;
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    wr_valid = 1'b0;
    chk("c_en0", reg_en, 8'h01);
    chk("c_d0", reg_d, 0);
    chk("c_busy0", clr_busy, 1);
    chk("c_qc0", q_count, 0);
    chk("c_ready0", wr_ready, 0);
    for (int k = 1; k < 8; k++) begin
      tick;
      chk("c_en", reg_en, 32'(1) << k);
      chk("c_d", reg_d, 0);
      chk("c_busy", clr_busy, 1);
      chk("c_qc", q_count, 0);
    end
    tick;
    chk("c_done_busy", clr_busy, 0);
    chk("c_done_en", reg_en, 0);
    chk("c_done_ready", wr_ready, 1);
    for (int r = 0; r < 8; r++) chk("c_row", rows[r], 0);
    tick;
    chk("c_no_ghost", reg_en, 0);

    // 5: clr_req and a write held during the clear
    clr_req = 1'b1;
    tick;
    chk("r_en0", reg_en, 8'h01);
    wr_valid = 1'b1;
    wr_addr = 3'd2;
    wr_data = 8'h5A;
    for (int k = 1; k < 8; k++) begin
      tick;
      chk("r_en", reg_en, 32'(1) << k);
      chk("r_ready", wr_ready, 0);
    end
    tick;
    clr_req = 1'b0;
    chk("r_busy_off", clr_busy, 0);
    chk("r_ready_on", wr_ready, 1);
    chk("r_en_off", reg_en, 0);
    tick;
    wr_valid = 1'b0;
    chk("r_qc", q_count, 1);
    tick;
    chk("r_wr_en", reg_en, 8'h04);
    chk("r_wr_d", reg_d, 8'h5A);
    tick;

    // 6: reset in the middle of a clear
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    tick;
    tick;
    tick;
    chk("x_en3", reg_en, 8'h08);
    rst_n = 1'b0;
    #1;
    chk("x_en_async", reg_en, 0);
    chk("x_busy_async", clr_busy, 0);
    chk("x_d_async", reg_d, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("x_busy", clr_busy, 0);
    chk("x_en", reg_en, 0);
    chk("x_qc", q_count, 0);
    chk("x_ready", wr_ready, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
